// File: rtl/conv_3x3_window_gen.sv
// Raster-scan pixel stream to 3x3 window generator: two line buffers feed a
// shifting 3x3 window, and one packed window is emitted per unpadded position.
`timescale 1ns/1ps
module conv_3x3_window_gen #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [9*PIX_W-1:0] win_out,
  output logic               win_valid,
  input  logic               win_ready,
  output logic               win_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [PIX_W-1:0]       lb0 [IMG_W];
  logic [PIX_W-1:0]       lb1 [IMG_W];
  logic [8:0][PIX_W-1:0]  win;
  logic [8:0][PIX_W-1:0]  win_next;
  logic                   accept;
  logic                   produce;
  logic                   col_end;
  logic                   row_end;

  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign col_end   = (col == CW'(IMG_W - 1));
  assign row_end   = (row == RW'(IMG_H - 1));
  assign produce   = accept && (row >= RW'(2)) && (col >= CW'(2));

  // Window after shifting left one column and inserting {lb1, lb0, pix_in} on the right.
  always_comb begin
    win_next    = win;
    win_next[0] = win[1];
    win_next[1] = win[2];
    win_next[2] = lb1[col];
    win_next[3] = win[4];
    win_next[4] = win[5];
    win_next[5] = lb0[col];
    win_next[6] = win[7];
    win_next[7] = win[8];
    win_next[8] = pix_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
      win <= '0;
    end else if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= pix_in;
      win      <= win_next;
    end
  end

  // A new window overrides a completing handshake so back-to-back windows stream at full rate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_out   <= '0;
      win_last  <= 1'b0;
    end else if (produce) begin
      win_valid <= 1'b1;
      win_out   <= win_next;
      win_last  <= col_end && row_end;
    end else if (win_valid && win_ready) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

endmodule
